// File: rtl/ula_inv.sv
// Inverse ALU: subtract in one cycle, restoring unsigned divide at one
// quotient bit per clock, behind a start/busy/done handshake.
module ula_inv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             h,
    input  logic [WIDTH-1:0] e0,
    input  logic [WIDTH-1:0] e1,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             div_zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        DIV
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] dvs_ext;
    logic             ge;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] q_nx;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh  = {rem_q, q_q[WIDTH-1]};
        dvs_ext = {2'b00, dvs_q};
        ge      = (rem_sh >= dvs_ext);
        rem_nx  = (WIDTH+1)'(ge ? (rem_sh - dvs_ext) : rem_sh);
        q_nx    = {q_q[WIDTH-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        r_d     = r_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (!h) begin
                        s_d    = e0 - e1;
                        r_d    = '0;
                        dz_d   = 1'b0;
                        done_d = 1'b1;
                    end else if (e1 == '0) begin
                        s_d    = '1;
                        r_d    = e0;
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        q_d     = e0;
                        dvs_d   = e1;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        busy_d  = 1'b1;
                        dz_d    = 1'b0;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                q_d   = q_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    s_d     = q_nx;
                    r_d     = WIDTH'(rem_nx);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign div_zero = dz_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ula_inv.sv
// Directed bench for ula_inv: subtract, divide, divide-by-zero,
// start-while-busy and reset-abort cases with hand-computed results.
module tb_ula_inv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        h;
    logic [15:0] e0, e1;
    logic [15:0] s, r;
    logic        div_zero, busy, done;

    int n_assert = 0;
    int n_fail   = 0;
    int n_done;
    int done_at;
    logic [15:0] cap_s, cap_r;

    always #5 clk = ~clk;

    ula_inv #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .h       (h),
        .e0      (e0),
        .e1      (e1),
        .s       (s),
        .r       (r),
        .div_zero(div_zero),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic hh, input logic [15:0] a,
                         input logic [15:0] b);
        @(negedge clk);
        start = 1'b1;
        h     = hh;
        e0    = a;
        e1    = b;
        step();
        @(negedge clk);
        start = 1'b0;
    endtask

    // Divide with full timing check; s/r must hold prev values while busy.
    task automatic run_div(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] es,
                           input logic [15:0] er, input logic [15:0] ps,
                           input logic [15:0] pr);
        issue(1'b1, a, b);
        chk({tag, "_busy0"}, busy, 1);
        chk({tag, "_done0"}, done, 0);
        for (int i = 1; i < 16; i++) begin
            step();
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_nodone"}, done, 0);
            chk({tag, "_shold"}, s, ps);
            chk({tag, "_rhold"}, r, pr);
        end
        step();
        chk({tag, "_busyfall"}, busy, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_s"}, s, es);
        chk({tag, "_r"}, r, er);
        chk({tag, "_dz"}, div_zero, 0);
        step();
        chk({tag, "_donepulse"}, done, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        h     = 1'b0;
        e0    = '0;
        e1    = '0;
        step();
        step();
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        issue(1'b0, 16'd7, 16'd3);
        chk("sub_s", s, 16'd4);
        chk("sub_r", r, 0);
        chk("sub_done", done, 1);
        chk("sub_busy", busy, 0);
        step();
        chk("sub_donepulse", done, 0);
        chk("sub_hold", s, 16'd4);

        issue(1'b0, 16'd3, 16'd5);
        chk("wrap_s", s, 16'hFFFE);
        chk("wrap_dz", div_zero, 0);
        chk("wrap_done", done, 1);

        run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 16'hFFFE, 16'd0);
        run_div("dffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 16'd14, 16'd2);
        run_div("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 16'hFFFF, 16'd0);

        issue(1'b1, 16'h1234, 16'd0);
        chk("dz_s", s, 16'hFFFF);
        chk("dz_r", r, 16'h1234);
        chk("dz_flag", div_zero, 1);
        chk("dz_done", done, 1);
        chk("dz_busy", busy, 0);
        step();
        chk("dz_busy2", busy, 0);
        chk("dz_donepulse", done, 0);
        issue(1'b0, 16'd10, 16'd4);
        chk("dzclr_s", s, 16'd6);
        chk("dzclr_flag", div_zero, 0);

        // Start pulse mid-divide must be ignored.
        issue(1'b1, 16'd100, 16'd7);
        n_done  = 0;
        done_at = 0;
        cap_s   = '0;
        cap_r   = '0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) begin
                start = 1'b1;
                h     = 1'b0;
                e0    = 16'd9;
                e1    = 16'd1;
            end
            step();
            if (done) begin
                n_done++;
                done_at = i;
                cap_s   = s;
                cap_r   = r;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("ign_ndone", n_done, 1);
        chk("ign_when", done_at, 16);
        chk("ign_s", cap_s, 16'd14);
        chk("ign_r", cap_r, 16'd2);

        // Reset on the 8th cycle of a divide aborts it silently.
        issue(1'b1, 16'd100, 16'd7);
        for (int i = 1; i < 7; i++) step();
        chk("abort_busy_pre", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("abort_s", s, 0);
        chk("abort_r", r, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) n_done++;
        end
        chk("abort_nodone", n_done, 0);
        chk("abort_idle", busy, 0);

        run_div("d50_6", 16'd50, 16'd6, 16'd8, 16'd2, 16'd0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_inv.md
Name: ula_inv

Overview:
Multi-cycle inverse-operation unit that pairs with the combinational sum/multiply ALU in the datapath. Given operands e0 and e1 and the same single-bit op select h, it computes the difference (h=0, the inverse of sum) or the unsigned quotient and remainder (h=1, the inverse of multiply). Division uses an iterative restoring algorithm, one quotient bit per clock. Control is a start/busy/done handshake so the sequencer can issue one operation at a time.

Parameters:
WIDTH, 16, operand and result width in bits; minimum 2.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
h  input  1  op select, sampled with start: 0=subtract, 1=divide.
e0  input  WIDTH  minuend or dividend, sampled with start.
e1  input  WIDTH  subtrahend or divisor, sampled with start.
s  output  WIDTH  difference or quotient; registered.
r  output  WIDTH  remainder (divide only); registered.
div_zero  output  1  set when the last completed op was a divide by zero.
busy  output  1  high while a divide is iterating.
done  output  1  one-cycle pulse on each completion.

Behaviour:
- Reset: when rst=1 at a clock edge, set s=0, r=0, div_zero=0, busy=0, done=0 and go to IDLE. Reset overrides start and aborts any divide in progress. No result from an aborted divide is produced.
- FSM states: IDLE and DIV.
- IDLE, start=0: outputs hold, done=0.
- IDLE, start=1, h=0 (subtract):
  - s <= (e0 - e1) mod 2^WIDTH; wrap-around is silent and no borrow flag is produced.
  - r <= 0, div_zero <= 0, done <= 1.
  - Stay in IDLE. Latency is 1 edge.
- IDLE, start=1, h=1, e1=0 (divide by zero):
  - s <= all ones, r <= e0, div_zero <= 1, done <= 1.
  - Stay in IDLE. Latency is 1 edge.
- IDLE, start=1, h=1, e1!=0:
  - Latch the dividend into the quotient shift register and the divisor into a register.
  - Clear the partial remainder (WIDTH+1 bits) and set count = WIDTH.
  - Set busy <= 1, div_zero <= 0, and go to DIV.
- DIV, each cycle:
  - rem' = {rem, q[MSB]}; q <<= 1.
  - If rem' >= divisor: rem = rem' - divisor and q[0] = 1; otherwise rem = rem' and q[0] = 0.
  - count decrements.
- DIV, final iteration (count reaches 0):
  - s <= final quotient, r <= final remainder[WIDTH-1:0], done <= 1, busy <= 0.
  - Go to IDLE.
- Divide timing: start is sampled at edge N. busy=1 after edges N .. N+WIDTH-1. done=1 and results are valid after edge N+WIDTH, which is WIDTH cycles of latency.
- s and r do not change during DIV. They show the previous result until the final update.
- start while busy=1 is ignored; it is neither queued nor able to corrupt state. The edge on which busy falls is still DIV, so start is not accepted on that edge.
- A new start is accepted in the cycle after done, giving back-to-back throughput of one divide per WIDTH+1 cycles.
- done is high for exactly one cycle per accepted op. It is never high while busy=1 except on the completion edge, where busy falls and done rises together.
- Arithmetic is unsigned throughout. The invariant e0 == s*e1 + r and r < e1 holds for every non-zero divisor.

Test Plan:
- Reset, then start h=0 with e0=7, e1=3 -> after 1 edge s=4, r=0, done pulses for 1 cycle, busy stays 0.
- Subtract wrap: e0=3, e1=5, h=0 -> s=0xFFFE, div_zero=0.
- Divide: e0=100, e1=7, h=1 -> busy high for 16 cycles; after edge N+16, s=14, r=2 and done pulses. Also e0=0xFFFF, e1=1 -> s=0xFFFF, r=0. Also e0=5, e1=9 -> s=0, r=5.
- Divide by zero: e0=0x1234, e1=0, h=1 -> after 1 edge s=0xFFFF, r=0x1234, div_zero=1, busy never rises. A following subtract clears div_zero.
- Start during busy: mid-divide of 100/7, pulse start with h=0, e0=9, e1=1 -> ignored; only one done pulse, with s=14, r=2.
- Reset mid-op: assert rst at cycle 8 of a divide -> next edge s=0, r=0, busy=0, no done pulse. A fresh 50/6 then gives s=8, r=2.
